// File: rtl/press_sequence_decoder.sv
// press_sequence_decoder
// Counts single-cycle button presses into a sequence. A sequence closes
// after WINDOW_COUNT quiet cycles, or at once when MAX_PRESSES is reached.
// The press count is then offered on a valid/ready interface.
// Optional feature: define PRESS_DECODER_OVERRUN_EN to add a sticky
// `overrun` flag. It records presses that were dropped while a command
// was waiting to be accepted.
module press_sequence_decoder #(
  parameter int unsigned WINDOW_COUNT  = 1_000_000,
  parameter int unsigned MAX_PRESSES   = 3,
  parameter bit          IN_ACTIVE_LOW = 1'b0,
  localparam int unsigned CNT_W        = $clog2(MAX_PRESSES + 1)
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             in_pulse,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [CNT_W-1:0] cmd_count
`ifdef PRESS_DECODER_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam int unsigned TMR_W = $clog2(WINDOW_COUNT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GATHER = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PRESSES);
  localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(MAX_PRESSES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] press_cnt;
  logic [TMR_W-1:0] gap_tmr;
  logic             press;

  // Normalise the input polarity so that 1 always means "press".
  always_comb begin
    press = in_pulse ^ IN_ACTIVE_LOW;
  end

  // Sequence FSM: gather presses, close the window, hold the command until it is accepted.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      press_cnt <= '0;
      gap_tmr   <= '0;
      cmd_valid <= 1'b0;
      cmd_count <= '0;
`ifdef PRESS_DECODER_OVERRUN_EN
      overrun   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state     <= GATHER;
            press_cnt <= CNT_ONE;
            gap_tmr   <= '0;
          end
        end
        GATHER: begin
          // A press wins over an expiring window, so the sequence is extended.
          if (press) begin
            gap_tmr <= '0;
            if (press_cnt == CNT_PEN) begin
              state     <= HOLD;
              press_cnt <= CNT_MAX;
              cmd_count <= CNT_MAX;
              cmd_valid <= 1'b1;
            end else begin
              press_cnt <= press_cnt + CNT_ONE;
            end
          end else if (gap_tmr == TMR_LAST) begin
            state     <= HOLD;
            cmd_count <= press_cnt;
            cmd_valid <= 1'b1;
          end else begin
            gap_tmr <= gap_tmr + TMR_W'(1);
          end
        end
        HOLD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            if (press) begin
              state     <= GATHER;
              press_cnt <= CNT_ONE;
              gap_tmr   <= '0;
            end else begin
              state <= IDLE;
            end
          end
`ifdef PRESS_DECODER_OVERRUN_EN
          else if (press) begin
            overrun <= 1'b1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_press_sequence_decoder.sv
// Directed bench for press_sequence_decoder with
// WINDOW_COUNT=16, MAX_PRESSES=3 and active-high input.
module tb_press_sequence_decoder;

  localparam int unsigned WIN = 16;
  localparam int unsigned MAXP = 3;
  localparam int unsigned CW = $clog2(MAXP + 1);

  logic          sys_clk = 1'b0;
  logic          rst_n;
  logic          in_pulse;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_count;
`ifdef PRESS_DECODER_OVERRUN_EN
  logic          overrun;
`endif

  int n_cmp = 0;
  int n_err = 0;

  press_sequence_decoder #(
    .WINDOW_COUNT (WIN),
    .MAX_PRESSES  (MAXP),
    .IN_ACTIVE_LOW(1'b0)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .in_pulse (in_pulse),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_count(cmd_count)
`ifdef PRESS_DECODER_OVERRUN_EN
    ,
    .overrun  (overrun)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a press that is registered on the next edge.
  task automatic press_once();
    in_pulse = 1'b1;
    tick();
    in_pulse = 1'b0;
  endtask

  // Run n edges and report whether cmd_valid stayed low throughout.
  task automatic quiet(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cmd_valid !== 1'b0) ok = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    rst_n     = 1'b0;
    in_pulse  = 1'b0;
    cmd_ready = 1'b0;
    #2;
    check("reset_valid", 32'(cmd_valid), 32'd0);
    check("reset_count", 32'(cmd_count), 32'd0);
`ifdef PRESS_DECODER_OVERRUN_EN
    check("reset_overrun", 32'(overrun), 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Single press: window closes 16 edges later, ready already high.
    cmd_ready = 1'b1;
    press_once();
    quiet(WIN - 1, ok);
    check("single_quiet", 32'(ok), 32'd1);
    tick();
    check("single_valid", 32'(cmd_valid), 32'd1);
    check("single_count", 32'(cmd_count), 32'd1);
    tick();
    check("single_ack", 32'(cmd_valid), 32'd0);
    check("single_count_held", 32'(cmd_count), 32'd1);

    // Two presses 10 apart; the command is held stable for 50 cycles.
    cmd_ready = 1'b0;
    press_once();
    ticks(9);
    press_once();
    quiet(WIN - 1, ok);
    check("two_quiet", 32'(ok), 32'd1);
    tick();
    check("two_valid", 32'(cmd_valid), 32'd1);
    check("two_count", 32'(cmd_count), 32'd2);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cmd_valid !== 1'b1 || cmd_count !== 2'd2) ok = 1'b0;
    end
    check("two_stable", 32'(ok), 32'd1);
    cmd_ready = 1'b1;
    tick();
    check("two_ack", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;

    // Three presses 5 apart: the command appears on the third press edge.
    press_once();
    ticks(4);
    press_once();
    ticks(4);
    check("three_pre", 32'(cmd_valid), 32'd0);
    press_once();
    check("three_valid", 32'(cmd_valid), 32'd1);
    check("three_count", 32'(cmd_count), 32'd3);
    cmd_ready = 1'b1;
    tick();
    check("three_ack", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;

    // A press on the edge where the timer is 15 extends the sequence.
    press_once();
    ticks(WIN - 1);
    press_once();
    check("edge_no_cmd", 32'(cmd_valid), 32'd0);
    quiet(WIN - 1, ok);
    check("edge_quiet", 32'(ok), 32'd1);
    tick();
    check("edge_valid", 32'(cmd_valid), 32'd1);
    check("edge_count", 32'(cmd_count), 32'd2);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;

    // A press while a command is pending is dropped. A press together with the handshake starts a new sequence.
    press_once();
    ticks(3);
    press_once();
    ticks(WIN);
    check("pend_valid", 32'(cmd_valid), 32'd1);
    check("pend_count", 32'(cmd_count), 32'd2);
    press_once();
    tick();
    check("drop_valid", 32'(cmd_valid), 32'd1);
    check("drop_count", 32'(cmd_count), 32'd2);
`ifdef PRESS_DECODER_OVERRUN_EN
    check("drop_overrun", 32'(overrun), 32'd1);
`endif
    cmd_ready = 1'b1;
    press_once();
    cmd_ready = 1'b0;
    check("hs_press_valid", 32'(cmd_valid), 32'd0);
    quiet(WIN - 1, ok);
    check("hs_press_quiet", 32'(ok), 32'd1);
    tick();
    check("hs_press_new_valid", 32'(cmd_valid), 32'd1);
    check("hs_press_new_count", 32'(cmd_count), 32'd1);
`ifdef PRESS_DECODER_OVERRUN_EN
    check("overrun_sticky", 32'(overrun), 32'd1);
`endif

    // Reset while a command is pending clears the outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", 32'(cmd_valid), 32'd0);
    check("rst_hold_count", 32'(cmd_count), 32'd0);
`ifdef PRESS_DECODER_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif
    tick();
    rst_n = 1'b1;

    // Reset in the middle of gathering (count 2) discards the sequence.
    press_once();
    ticks(3);
    press_once();
    ticks(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gather_count", 32'(cmd_count), 32'd0);
    check("rst_gather_valid", 32'(cmd_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    quiet(40, ok);
    check("rst_no_cmd", 32'(ok), 32'd1);

    // A press is recognised on the first edge after reset is released.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    press_once();
    ticks(WIN - 1);
    check("post_rst_pre", 32'(cmd_valid), 32'd0);
    tick();
    check("post_rst_valid", 32'(cmd_valid), 32'd1);
    check("post_rst_count", 32'(cmd_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/press_sequence_decoder.md
PRESS_SEQUENCE_DECODER -- requirements
Module: press_sequence_decoder

Interface
REQ-001 Parameter WINDOW_COUNT, default 1_000_000: number of clock cycles without a press that closes a press sequence; legal range 2 or more.
REQ-002 Parameter MAX_PRESSES, default 3: largest press count reported; legal range 2 or more.
REQ-003 Parameter IN_ACTIVE_LOW, default 0: polarity of in_pulse; 0 means active-high.
REQ-004 Local constant CNT_W = $clog2(MAX_PRESSES+1) SHALL size cmd_count.
REQ-005 sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_pulse  input  1  one-cycle press pulse, already synchronous to sys_clk and debounced upstream.
REQ-008 cmd_valid  output  1  a completed press sequence is presented.
REQ-009 cmd_ready  input  1  the consumer accepts cmd_count this cycle.
REQ-010 cmd_count  output  CNT_W  number of presses in the sequence, 1..MAX_PRESSES.
REQ-011 overrun  output  1  sticky flag for a press dropped while a command was pending; present only with the macro in REQ-034.

Function
REQ-012 The FSM SHALL have three states: IDLE, GATHER and HOLD; all outputs SHALL be registered.
REQ-013 A press SHALL be in_pulse at its active level, as set by IN_ACTIVE_LOW, sampled on a rising edge.
REQ-014 IDLE + press -> GATHER, with press counter = 1 and gap timer = 0.
REQ-015 GATHER + press with counter < MAX_PRESSES-1 -> counter +1, timer = 0, stay in GATHER.
REQ-016 GATHER + press bringing counter to MAX_PRESSES -> HOLD immediately, with cmd_count = MAX_PRESSES and cmd_valid = 1 on the same edge.
REQ-017 GATHER with no press -> timer +1; when timer == WINDOW_COUNT-1 -> HOLD, cmd_count = counter, cmd_valid = 1.
REQ-018 Latency: if the last press is registered on edge E0, cmd_valid SHALL rise on edge E0+WINDOW_COUNT.
REQ-019 A press in the same cycle as timer == WINDOW_COUNT-1 SHALL take priority, per REQ-015 and REQ-016; the sequence is extended.
REQ-020 The timer SHALL never exceed WINDOW_COUNT-1 and the counter SHALL never exceed MAX_PRESSES; no wrap-around is permitted.
REQ-021 In HOLD, cmd_valid and cmd_count SHALL stay stable until a cycle with cmd_ready = 1.
REQ-022 Handshake (cmd_valid & cmd_ready) with no press -> IDLE; cmd_valid = 0 on that edge.
REQ-023 Handshake together with a press -> GATHER, counter = 1, timer = 0, cmd_valid = 0; the new press is not lost.
REQ-024 A press in HOLD without a handshake SHALL be dropped; the pending command is unchanged.
REQ-025 cmd_ready SHALL be ignored while cmd_valid = 0.
REQ-026 cmd_count SHALL hold its last value outside HOLD; it is meaningful only while cmd_valid = 1.

Reset
REQ-027 rst_n low SHALL immediately, independent of sys_clk, force state IDLE.
REQ-028 rst_n low SHALL immediately force cmd_valid = 0, cmd_count = 0, counter = 0, timer = 0 and overrun = 0.
REQ-029 Reset mid-GATHER or mid-HOLD SHALL discard the partial or pending sequence; no command is emitted afterwards.
REQ-030 The first press is recognised on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro PRESS_DECODER_OVERRUN_EN, when defined, SHALL include the overrun port.
REQ-032 With PRESS_DECODER_OVERRUN_EN, overrun SHALL be set by a press dropped under REQ-024.
REQ-033 With PRESS_DECODER_OVERRUN_EN, overrun SHALL be cleared only by reset.
REQ-034 Without PRESS_DECODER_OVERRUN_EN, the overrun port and its logic SHALL be absent; dropped presses are silent and all other behaviour is identical.

Verification (WINDOW_COUNT=16, MAX_PRESSES=3, IN_ACTIVE_LOW=0)
REQ-035 One pulse at edge E0, cmd_ready=1 -> cmd_valid high on edge E0+16 for 1 cycle, cmd_count=1, then IDLE.
REQ-036 Two pulses 10 cycles apart, cmd_ready=0 -> cmd_valid at 16 edges after the 2nd pulse, cmd_count=2, held stable for 50 cycles until cmd_ready=1.
REQ-037 Three pulses 5 cycles apart -> cmd_valid on the edge registering the 3rd pulse, cmd_count=3, no window wait.
REQ-038 Pulse exactly when timer==15 -> no command emitted; the count becomes 2 and the window restarts.
REQ-039 Pending command, cmd_ready=0, extra pulse -> command unchanged; overrun=1 if the macro is defined. Then a pulse coinciding with cmd_ready=1 -> new GATHER with count=1, later reported as cmd_count=1.
REQ-040 rst_n low for 1 cycle mid-GATHER with count=2 -> outputs 0 asynchronously; no cmd_valid in the following 40 cycles.
